// File: rtl/ram_np_pkg.sv
// rtl/ram_np_pkg.sv - shared types, limits and lane helpers for the multi-port RAM
package ram_np_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int NPORTS_MAX = 8;
  localparam int RD_LAT_MAX = 2;
  localparam int DWID_MAX   = 256;
  localparam int BE_MAX     = DWID_MAX / 8;

  function automatic int bytes_of(input int dwid);
    return dwid / 8;
  endfunction

  // Callers zero-extend narrower words; lanes with a clear enable keep old_w.
  function automatic logic [DWID_MAX-1:0] lane_merge(input logic [DWID_MAX-1:0] old_w,
                                                     input logic [DWID_MAX-1:0] new_w,
                                                     input logic [BE_MAX-1:0]   be);
    logic [DWID_MAX-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_MAX; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_np_arb_rdpipe.sv
// rtl/ram_np_arb_rdpipe.sv - per-port read-latency pipe; output data holds between valid pulses
module ram_np_rdpipe
  import ram_np_pkg::*;
#(
  parameter int DWID   = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DWID-1:0] in_data,
  output logic            out_valid,
  output logic [DWID-1:0] out_data
);

  localparam int LAT = (RD_LAT < 1) ? 1 : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0]  v;
  logic [DWID-1:0] dq [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) dq[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) dq[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) dq[i] <= dq[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = dq[LAT-1];

endmodule

// File: rtl/ram_np_arb.sv
// rtl/ram_np_arb.sv - NPORTS-port shared RAM with lane writes, same-address arbitration and clear sweep
module ram_np_arb
  import ram_np_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int DEPTH      = 256,
  parameter int AWID       = 8,
  parameter int DWID       = 16,
  parameter int RD_LAT     = 1,
  parameter int RDW_NEW    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*DWID/8-1:0] be,
  input  logic [NPORTS*AWID-1:0]   addr,
  input  logic [NPORTS*DWID-1:0]   din,
  output logic                     ready,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS*DWID-1:0]   dout,
  output logic                     oor_err,
  output logic                     wr_collide
);

  localparam int NP = (NPORTS < NPORTS_MAX) ? NPORTS : NPORTS_MAX;
  localparam int NB = bytes_of(DWID);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWID:0] DEPTH_W = (AWID+1)'(DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

  state_t          state;
  logic [IW-1:0]   clr_cnt;
  logic [DWID-1:0] mem [DEPTH];

  logic [AWID-1:0] a       [NP];
  logic [IW-1:0]   ia      [NP];
  logic [DWID-1:0] d       [NP];
  logic [NB-1:0]   b       [NP];
  logic [DWID-1:0] old_w   [NP];
  logic [DWID-1:0] merged  [NP];
  logic [DWID-1:0] rd_data [NP];
  logic [NP-1:0]   acc, wr_acc, rd_acc, in_rng;
  logic            collide, oor_hit;

  always_comb begin
    collide = 1'b0;
    oor_hit = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a[p]      = addr[p*AWID +: AWID];
      d[p]      = din[p*DWID +: DWID];
      b[p]      = be[p*NB +: NB];
      in_rng[p] = {1'b0, a[p]} < DEPTH_W;
      ia[p]     = in_rng[p] ? a[p][IW-1:0] : '0;
      acc[p]    = req[p] & ready;
      wr_acc[p] = acc[p] & we[p];
      rd_acc[p] = acc[p] & ~we[p];
      oor_hit   = oor_hit | (acc[p] & ~in_rng[p]);
    end
    // merged[p]: the word at port p's address after every accepted write this cycle,
    // applied in ascending port order so the highest enabled port wins each lane.
    for (int p = 0; p < NP; p++) begin
      old_w[p]  = mem[ia[p]];
      merged[p] = old_w[p];
      for (int q = 0; q < NP; q++) begin
        if (wr_acc[q] && in_rng[q] && a[q] == a[p])
          merged[p] = DWID'(lane_merge(DWID_MAX'(merged[p]), DWID_MAX'(d[q]), BE_MAX'(b[q])));
        if (q > p && wr_acc[p] && wr_acc[q] && a[q] == a[p])
          collide = 1'b1;
      end
      rd_data[p] = !in_rng[p] ? '0 : (RDW_NEW != 0) ? merged[p] : old_w[p];
    end
  end

  // Ports hitting the same address all store the identical merged word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (wr_acc[p] && in_rng[p]) mem[ia[p]] <= merged[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (CLR_ON_RST != 0) ? ST_INIT : ST_RUN;
      ready      <= (CLR_ON_RST == 0);
      clr_cnt    <= '0;
      oor_err    <= 1'b0;
      wr_collide <= 1'b0;
    end else begin
      wr_collide <= collide;
      if (oor_hit) oor_err <= 1'b1;
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + IW'(1);
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    ram_np_rdpipe #(
      .DWID   (DWID),
      .RD_LAT (RD_LAT)
    ) u_rdpipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_acc[p]),
      .in_data   (rd_data[p]),
      .out_valid (rvalid[p]),
      .out_data  (dout[p*DWID +: DWID])
    );
  end

endmodule

// File: tb/tb_ram_np_arb.sv
// tb/tb_ram_np_arb.sv - two configurations driven in lockstep against a scoreboard model
module tb_ram_np_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [5:0]  be = '0;
  logic [23:0] addr = '0;
  logic [47:0] din = '0;

  logic        rdy_a, rdy_b, oor_a, oor_b, col_a, col_b;
  logic [2:0]  rv_a, rv_b;
  logic [47:0] do_a, do_b;

  always #5 clk = ~clk;

  ram_np_arb #(.NPORTS(3), .DEPTH(200), .AWID(8), .DWID(16), .RD_LAT(2), .RDW_NEW(0), .CLR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .ready(rdy_a), .rvalid(rv_a), .dout(do_a), .oor_err(oor_a), .wr_collide(col_a)
  );

  ram_np_arb #(.NPORTS(3), .DEPTH(16), .AWID(8), .DWID(16), .RD_LAT(1), .RDW_NEW(1), .CLR_ON_RST(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .ready(rdy_b), .rvalid(rv_b), .dout(do_b), .oor_err(oor_b), .wr_collide(col_b)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [2][256];
  int          dep  [2] = '{200, 16};
  int          lat  [2] = '{2, 1};
  int          rdwn [2] = '{0, 1};
  logic        exp_oor [2] = '{1'b0, 1'b0};
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every cycle advance goes through here: outputs are sampled on the falling edge.
  task automatic tick();
    logic [2:0]  rv;
    logic [47:0] dd;
    int          idx;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      rv = (k == 0) ? rv_a : rv_b;
      dd = (k == 0) ? do_a : do_b;
      for (int p = 0; p < 3; p++) begin
        if (rv[p]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].dut == k && sb[i].port == p) idx = i;
          chk($sformatf("rvalid_expected d%0d p%0d", k, p), 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            chk($sformatf("dout d%0d p%0d", k, p), 32'(dd[p*16 +: 16]), 32'(sb[idx].data));
            chk($sformatf("latency d%0d p%0d", k, p), 32'(cyc), 32'(sb[idx].cyc));
            sb.delete(idx);
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        chk($sformatf("rvalid_missing d%0d p%0d", sb[i].dut, sb[i].port), 32'(sb[i].cyc), 32'(cyc));
        sb.delete(i);
      end
    end
    #1;
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [5:0] b,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    logic [7:0]  av [3];
    logic [15:0] dv [3];
    logic [15:0] pre, post;
    logic        ec;
    exp_t        e;
    av[0] = a0; av[1] = a1; av[2] = a2;
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    ec = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int q = p + 1; q < 3; q++)
        if (r[p] && r[q] && w[p] && w[q] && av[p] == av[q]) ec = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) begin
        if (r[p] && !w[p]) begin
          if (int'(av[p]) >= dep[k]) begin
            e.data = 16'h0000;
          end else begin
            pre  = mdl[k][av[p]];
            post = pre;
            for (int q = 0; q < 3; q++)
              if (r[q] && w[q] && av[q] == av[p])
                for (int l = 0; l < 2; l++)
                  if (b[q*2 + l]) post[l*8 +: 8] = dv[q][l*8 +: 8];
            e.data = (rdwn[k] != 0) ? post : pre;
          end
          e.dut  = k;
          e.port = p;
          e.cyc  = cyc + lat[k];
          sb.push_back(e);
        end
      end
      for (int q = 0; q < 3; q++)
        if (r[q] && w[q] && int'(av[q]) < dep[k])
          for (int l = 0; l < 2; l++)
            if (b[q*2 + l]) mdl[k][av[q]][l*8 +: 8] = dv[q][l*8 +: 8];
      for (int p = 0; p < 3; p++)
        if (r[p] && int'(av[p]) >= dep[k]) exp_oor[k] = 1'b1;
    end
    req  = r;
    we   = w;
    be   = b;
    addr = {a2, a1, a0};
    din  = {d2, d1, d0};
    tick();
    req = '0;
    we  = '0;
    chk("wr_collide a", 32'(col_a), 32'(ec));
    chk("wr_collide b", 32'(col_b), 32'(ec));
    chk("oor_err a", 32'(oor_a), 32'(exp_oor[0]));
    chk("oor_err b", 32'(oor_b), 32'(exp_oor[1]));
  endtask

  task automatic idle();
    step(3'b000, 3'b000, 6'b0, 8'd0, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic pulse_rst(input int n);
    rst = 1'b1;
    sb.delete();
    repeat (n) tick();
    chk("reset ready a", 32'(rdy_a), 32'd0);
    chk("reset ready b", 32'(rdy_b), 32'd0);
    chk("reset rvalid a", 32'(rv_a), 32'd0);
    chk("reset rvalid b", 32'(rv_b), 32'd0);
    chk("reset dout a", do_a[31:0], 32'd0);
    chk("reset dout b", do_b[31:0], 32'd0);
    chk("reset oor_err a", 32'(oor_a), 32'd0);
    chk("reset oor_err b", 32'(oor_b), 32'd0);
    chk("reset wr_collide a", 32'(col_a), 32'd0);
    chk("reset wr_collide b", 32'(col_b), 32'd0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < dep[k]; i++) mdl[k][i] = 16'h0000;
    exp_oor[0] = 1'b0;
    exp_oor[1] = 1'b0;
    rst = 1'b0;
  endtask

  // ready must stay low for DEPTH-1 edges after release and be high at edge DEPTH.
  task automatic wait_ready();
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == dep[0] - 1) chk("ready early a", 32'(rdy_a), 32'd0);
      if (n == dep[0])     chk("ready rise a", 32'(rdy_a), 32'd1);
      if (n == dep[1] - 1) chk("ready early b", 32'(rdy_b), 32'd0);
      if (n == dep[1])     chk("ready rise b", 32'(rdy_b), 32'd1);
    end
  endtask

  initial begin
    pulse_rst(2);
    wait_ready();

    // preload then reset: sweep must zero every word
    for (int i = 0; i < 16; i++)
      step(3'b001, 3'b001, 6'b000011, 8'(i), 8'd0, 8'd0, 16'hFFFF, 16'h0, 16'h0);
    pulse_rst(1);
    wait_ready();
    for (int i = 0; i < 16; i++)
      step(3'b011, 3'b000, 6'b0, 8'(i), 8'(15 - i), 8'd0, 16'h0, 16'h0, 16'h0);

    // reset while the sweep counter is at 9
    pulse_rst(1);
    repeat (9) tick();
    pulse_rst(1);
    wait_ready();

    // byte lanes
    step(3'b001, 3'b001, 6'b000011, 8'd5, 8'd0, 8'd0, 16'hABCD, 16'h0, 16'h0);
    step(3'b001, 3'b001, 6'b000010, 8'd5, 8'd0, 8'd0, 16'h12FF, 16'h0, 16'h0);
    step(3'b111, 3'b000, 6'b0, 8'd5, 8'd5, 8'd5, 16'h0, 16'h0, 16'h0);

    // same-address collision across three ports
    step(3'b111, 3'b111, {2'b00, 2'b01, 2'b11}, 8'd7, 8'd7, 8'd7, 16'h1111, 16'h2222, 16'h3333);
    idle();
    step(3'b100, 3'b000, 6'b0, 8'd0, 8'd0, 8'd7, 16'h0, 16'h0, 16'h0);

    // distinct addresses in one cycle: no collision
    step(3'b111, 3'b111, 6'b111111, 8'd8, 8'd9, 8'd10, 16'h0808, 16'h0909, 16'h0A0A);
    step(3'b111, 3'b000, 6'b0, 8'd10, 8'd8, 8'd9, 16'h0, 16'h0, 16'h0);

    // read-during-write
    step(3'b001, 3'b001, 6'b000011, 8'd3, 8'd0, 8'd0, 16'h0001, 16'h0, 16'h0);
    step(3'b011, 3'b001, 6'b000011, 8'd3, 8'd3, 8'd0, 16'h5A5A, 16'h0, 16'h0);
    step(3'b001, 3'b000, 6'b0, 8'd3, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0);

    // out of range write, read, and sticky flag
    step(3'b001, 3'b001, 6'b000011, 8'd210, 8'd0, 8'd0, 16'hBEEF, 16'h0, 16'h0);
    step(3'b010, 3'b000, 6'b0, 8'd0, 8'd250, 8'd0, 16'h0, 16'h0, 16'h0);
    step(3'b011, 3'b000, 6'b0, 8'd2, 8'd210, 8'd0, 16'h0, 16'h0, 16'h0);
    repeat (3) idle();

    // reset one cycle after a read: the RD_LAT=2 response must never appear
    step(3'b001, 3'b000, 6'b0, 8'd5, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0);
    pulse_rst(1);
    wait_ready();
    step(3'b001, 3'b000, 6'b0, 8'd5, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0);
    repeat (4) tick();
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ram_np_arb.md
Name: ram_np_arb

Overview:
- Parametrised successor to the two-port RAM: one synchronous memory array shared by NPORTS identical ports, all on one clock.
- Adds:
  - per-port request/ready handshake
  - byte-lane write enables
  - configurable read latency and read-during-write mode
  - deterministic same-address write arbitration
  - out-of-range address detection
  - a post-reset clear sweep
- Used as the shared buffer between multiple controllers in a datapath.

Parameters:
- NPORTS, 2, number of ports (1..8).
- DEPTH, 256, number of words (any value 2..2**AWID; need not be a power of two).
- AWID, 8, address width.
- DWID, 16, data width; must be a multiple of 8.
- RD_LAT, 1, read latency in cycles from an accepted request to rvalid (1 or 2).
- RDW_NEW, 0, read-during-write to the same address: 0 = old data, 1 = new (arbitrated) data.
- CLR_ON_RST, 1, 1 = zero every word after reset before accepting requests.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- req, in, NPORTS, per-port request strobe.
- we, in, NPORTS, per-port write (1) / read (0) select.
- be, in, NPORTS*DWID/8, byte enables; port p uses slice p. Ignored on reads.
- addr, in, NPORTS*AWID, per-port address.
- din, in, NPORTS*DWID, per-port write data.
- ready, out, 1, common: requests are accepted only while ready is high.
- rvalid, out, NPORTS, read data valid.
- dout, out, NPORTS*DWID, read data; holds its last value when rvalid is low.
- oor_err, out, 1, sticky: set by any accepted request with addr >= DEPTH.
- wr_collide, out, 1, one-cycle pulse when 2+ accepted writes target the same address.

Behaviour:
- Reset: rst high at a rising clk edge sets rvalid=0, dout=0, oor_err=0, wr_collide=0, ready=0, empties the read pipeline, and enters INIT (CLR_ON_RST=1) or RUN (CLR_ON_RST=0). Memory contents are not touched by rst itself.
- FSM states:
  - INIT: a counter writes 0 to address 0..DEPTH-1, one word per cycle; ready=0; all requests ignored. After writing DEPTH-1, go to RUN. Time from rst deasserted to ready=1 is exactly DEPTH cycles.
  - RUN: ready=1.
  - rst in any state returns to the reset condition. An interrupted sweep restarts from address 0. In-flight reads are dropped with no rvalid.
- Acceptance: a port's request is accepted when req[p] && ready at a rising edge. Every accepted read produces exactly one rvalid pulse. Reads are never stalled in RUN.
- Writes:
  - Lane b of word addr is updated with din lane b when be lane b = 1.
  - be = 0 is a legal no-op write that still counts for collision detection.
  - For multiple accepted writes to the same address, process ports in ascending index; a higher index overwrites lower-index ports only on its enabled lanes. Net effect: per lane, the highest-index port with that lane enabled wins. Set wr_collide for that one cycle.
- Reads:
  - dout/rvalid[p] appear exactly RD_LAT cycles after acceptance.
  - When a read and a write to the same address are accepted in the same cycle:
    - RDW_NEW=0: the read returns pre-write data.
    - RDW_NEW=1: the read returns post-arbitration merged data.
- Out of range (addr >= DEPTH):
  - Write: discarded, memory unchanged.
  - Read: rvalid still pulses, dout=0.
  - Either sets oor_err, which clears only on rst.
- Widths: the byte count DWID/8 is computed with integer division. No arithmetic wraps: the INIT counter stops at DEPTH-1.
- Implementation: the memory is a single array written in one clocked process. No latches, and no combinational path from inputs to outputs.

Decomposition:
- Package ram_np_pkg:
  - state typedef (INIT, RUN)
  - function bytes_of(DWID)
  - a lane-merge function (old word, new word, byte enables)
  - localparam limits NPORTS_MAX=8, RD_LAT_MAX=2
- One sub-module, ram_np_rdpipe: a per-port read-latency shift register (valid + data, depth RD_LAT), instantiated NPORTS times in a generate loop.

Test Plan:
- Post-reset clear, DEPTH=16, CLR_ON_RST=1: preload 0xFFFF, pulse rst for 1 cycle → ready rises exactly 16 cycles later; reading addresses 0..15 returns 0x0000.
- Byte lanes: write 0xABCD at addr 5 with be=2'b11, then 0x12xx with be=2'b10 → read of addr 5 gives 0x12CD after RD_LAT cycles (checked with RD_LAT=1 and RD_LAT=2).
- Write collision, NPORTS=3, same cycle, addr 7:
  - port0: 0x1111, be=11
  - port1: 0x2222, be=01
  - port2: 0x3333, be=00
  - → wr_collide pulses once; addr 7 holds 0x1122.
- Read-during-write: port0 writes 0x5A5A to addr 3 (old 0x0001) while port1 reads addr 3 → dout[1]=0x0001 with RDW_NEW=0, 0x5A5A with RDW_NEW=1.
- Out of range, DEPTH=200:
  - write 0xBEEF to addr 210 → memory unchanged; oor_err=1 and stays set.
  - read addr 250 → rvalid pulses with dout=0.
  - only rst clears oor_err.
- Reset mid-operation:
  - rst during INIT at counter=9 → sweep restarts from address 0 and ready rises DEPTH cycles after release.
  - rst one cycle after a RD_LAT=2 read → no rvalid is ever produced for that read.
